// File: rtl/dmem_arb_pkg.sv
// Shared types, func3 codes and the alignment rule for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Only the size bits of func3 matter: halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] f3_size, input logic [1:0] addr_lo);
        return ((f3_size == 2'b01) && addr_lo[0]) ||
               ((f3_size == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way grant picker: round-robin on ties, or fixed port-0 priority.
module dmem_arb_rr #(
    parameter int CORE_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last_grant;

    // Grant decision; a tie goes to the port that did not win last time.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_en) begin
            if (CORE_PRIO != 0) begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1 & ~i_req0;
            end else if (i_req0 && i_req1) begin
                o_gnt0 = r_last_grant;
                o_gnt1 = ~r_last_grant;
            end else begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1;
            end
        end
    end

    // Remember the last winner; reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (o_gnt0 || o_gnt1) begin
            r_last_grant <= o_gnt1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (port 0) and a debug/DMA master (port 1).
//
// state | meaning
// IDLE  | waiting for a request, grant issued here only
// RD    | mem_rd held for RD_LAT cycles, data captured in the last one
// WR    | single-cycle mem_wr strobe
// RESP  | one-cycle response strobe to the owning port
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int CORE_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic          p0_we,
    input  logic [2:0]    p0_func3,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_rsp_valid,
    output logic          p0_rsp_err,
    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic          p1_we,
    input  logic [2:0]    p1_func3,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_rsp_valid,
    output logic          p1_rsp_err,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_func3,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(RD_LAT - 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_lat_cnt;
    logic [2:0]    r_func3;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_owner;
    logic          r_err;

    logic          w_idle, w_gnt0, w_gnt1, w_gnt;
    logic          w_sel_we, w_sel_err;
    logic [2:0]    w_sel_f3;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // Gating with rst keeps ready low while reset is asserted.
    assign w_idle = (r_state == IDLE) && rst;

    dmem_arb_rr #(.CORE_PRIO(CORE_PRIO)) u_rr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_idle),
        .i_req0 (p0_valid),
        .i_req1 (p1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // Mux the winning request's fields and classify alignment.
    always_comb begin
        w_gnt       = w_gnt0 | w_gnt1;
        w_sel_we    = w_gnt1 ? p1_we    : p0_we;
        w_sel_f3    = w_gnt1 ? p1_func3 : p0_func3;
        w_sel_addr  = w_gnt1 ? p1_addr  : p0_addr;
        w_sel_wdata = w_gnt1 ? p1_wdata : p0_wdata;
        w_sel_err   = misaligned(w_sel_f3[1:0], w_sel_addr[1:0]);
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_gnt) w_next = w_sel_err ? RESP : (w_sel_we ? WR : RD);
            RD:   if (r_lat_cnt == LAT_LAST) w_next = RESP;
            WR:   w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Request latch, latency counter and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_cnt <= '0;
            r_func3   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_owner   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_func3 <= w_sel_f3;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_owner <= w_gnt1;
                r_err   <= w_sel_err;
                if (w_sel_err || w_sel_we) r_rdata <= '0;
            end
            if (r_state == RD) begin
                if (r_lat_cnt == LAT_LAST) begin
                    r_lat_cnt <= '0;
                    r_rdata   <= mem_rdata;
                end else begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                end
            end
        end
    end

    assign p0_ready     = w_gnt0;
    assign p1_ready     = w_gnt1;
    assign p0_rsp_valid = (r_state == RESP) && !r_owner;
    assign p1_rsp_valid = (r_state == RESP) &&  r_owner;
    assign p0_rsp_err   = p0_rsp_valid & r_err;
    assign p1_rsp_err   = p1_rsp_valid & r_err;
    assign rsp_rdata    = r_rdata;
    assign mem_rd       = (r_state == RD);
    assign mem_wr       = (r_state == WR);
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_func3    = r_func3;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: instance A is round-robin with RD_LAT=1, instance B is core-priority with RD_LAT=3.
import dmem_arb_pkg::*;

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [2:0]  p0_func3, p1_func3;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;

    logic        p0_ready_a, p1_ready_a, p0_rsp_valid_a, p1_rsp_valid_a, p0_rsp_err_a, p1_rsp_err_a;
    logic        mem_rd_a, mem_wr_a;
    logic [31:0] rsp_rdata_a, mem_addr_a, mem_wdata_a;
    logic [2:0]  mem_func3_a;

    logic        p0_ready_b, p1_ready_b, p0_rsp_valid_b, p1_rsp_valid_b, p0_rsp_err_b, p1_rsp_err_b;
    logic        mem_rd_b, mem_wr_b;
    logic [31:0] rsp_rdata_b, mem_addr_b, mem_wdata_b;
    logic [2:0]  mem_func3_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .CORE_PRIO(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready_a), .p0_we(p0_we), .p0_func3(p0_func3),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid_a), .p0_rsp_err(p0_rsp_err_a),
        .p1_valid(p1_valid), .p1_ready(p1_ready_a), .p1_we(p1_we), .p1_func3(p1_func3),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid_a), .p1_rsp_err(p1_rsp_err_a),
        .rsp_rdata(rsp_rdata_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_func3(mem_func3_a), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .CORE_PRIO(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready_b), .p0_we(p0_we), .p0_func3(p0_func3),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid_b), .p0_rsp_err(p0_rsp_err_b),
        .p1_valid(p1_valid), .p1_ready(p1_ready_b), .p1_we(p1_we), .p1_func3(p1_func3),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid_b), .p1_rsp_err(p1_rsp_err_b),
        .rsp_rdata(rsp_rdata_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_func3(mem_func3_b), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (n) nxt();
    endtask

    initial begin
        rst = 1'b0;
        p0_valid = 1'b1; p0_we = 1'b0; p0_func3 = 3'd0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_func3 = 3'd0; p1_addr = '0; p1_wdata = '0;
        mem_rdata = '0;

        // Reset state, with a request pending to prove ready stays low.
        repeat (2) @(negedge clk);
        chk("rst_p0_ready", p0_ready_a, 1'b0);
        chk("rst_mem_rd", mem_rd_a, 1'b0);
        chk("rst_mem_wr", mem_wr_a, 1'b0);
        chk("rst_rdata", rsp_rdata_a, 32'h0);
        chk("rst_mem_addr", mem_addr_a, 32'h0);
        chk("rst_rsp_valid", p0_rsp_valid_a, 1'b0);
        rst = 1'b1;
        p0_valid = 1'b0;

        // p0 LW 0x10, RD_LAT=1.
        nxt();
        p0_valid = 1'b1; p0_we = 1'b0; p0_func3 = F3_W; p0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("lw_p0_ready", p0_ready_a, 1'b1);
        chk("lw_p1_ready", p1_ready_a, 1'b0);
        chk("lw_c0_mem_rd", mem_rd_a, 1'b0);
        nxt(); p0_valid = 1'b0;
        @(negedge clk);
        chk("lw_c1_mem_rd", mem_rd_a, 1'b1);
        chk("lw_c1_addr", mem_addr_a, 32'h10);
        chk("lw_c1_func3", mem_func3_a, F3_W);
        chk("lw_c1_rsp", p0_rsp_valid_a, 1'b0);
        nxt(); @(negedge clk);
        chk("lw_c2_rsp", p0_rsp_valid_a, 1'b1);
        chk("lw_c2_err", p0_rsp_err_a, 1'b0);
        chk("lw_c2_rdata", rsp_rdata_a, 32'hDEADBEEF);
        chk("lw_c2_mem_rd", mem_rd_a, 1'b0);
        chk("lw_c2_p1_rsp", p1_rsp_valid_a, 1'b0);
        nxt(); @(negedge clk);
        chk("lw_c3_rsp", p0_rsp_valid_a, 1'b0);
        chk("lw_c3_rdata_hold", rsp_rdata_a, 32'hDEADBEEF);
        idle(6);

        // p1 LH 0x13: misaligned, response one cycle after grant, no memory strobe.
        p1_valid = 1'b1; p1_we = 1'b0; p1_func3 = F3_H; p1_addr = 32'h13;
        @(negedge clk);
        chk("err_p1_ready_a", p1_ready_a, 1'b1);
        chk("err_p1_ready_b", p1_ready_b, 1'b1);
        nxt(); p1_valid = 1'b0;
        @(negedge clk);
        chk("err_rsp_a", p1_rsp_valid_a, 1'b1);
        chk("err_flag_a", p1_rsp_err_a, 1'b1);
        chk("err_flag_b", p1_rsp_err_b, 1'b1);
        chk("err_mem_rd", mem_rd_a, 1'b0);
        chk("err_mem_wr", mem_wr_a, 1'b0);
        chk("err_rdata", rsp_rdata_a, 32'h0);
        chk("err_p0_rsp", p0_rsp_valid_a, 1'b0);
        nxt(); @(negedge clk);
        chk("err_rsp_end", p1_rsp_valid_a, 1'b0);
        chk("err_mem_rd_end", mem_rd_a, 1'b0);
        idle(3);

        // Both ports storing continuously: A alternates p0,p1,...; B grants p0 every time.
        p0_valid = 1'b1; p0_we = 1'b1; p0_func3 = F3_W; p0_addr = 32'h100; p0_wdata = 32'hA0A0;
        p1_valid = 1'b1; p1_we = 1'b1; p1_func3 = F3_W; p1_addr = 32'h200; p1_wdata = 32'hB1B1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_p0_ready_a", p0_ready_a, (k % 2) == 0);
            chk("rr_p1_ready_a", p1_ready_a, (k % 2) == 1);
            chk("prio_p0_ready_b", p0_ready_b, 1'b1);
            chk("prio_p1_ready_b", p1_ready_b, 1'b0);
            nxt(); @(negedge clk);
            chk("rr_mem_wr_a", mem_wr_a, 1'b1);
            chk("rr_mem_rd_a", mem_rd_a, 1'b0);
            chk("rr_addr_a", mem_addr_a, ((k % 2) == 0) ? 32'h100 : 32'h200);
            chk("rr_wdata_a", mem_wdata_a, ((k % 2) == 0) ? 32'hA0A0 : 32'hB1B1);
            chk("prio_mem_wr_b", mem_wr_b, 1'b1);
            chk("prio_addr_b", mem_addr_b, 32'h100);
            nxt(); @(negedge clk);
            chk("rr_p0_rsp_a", p0_rsp_valid_a, (k % 2) == 0);
            chk("rr_p1_rsp_a", p1_rsp_valid_a, (k % 2) == 1);
            chk("rr_rdata_a", rsp_rdata_a, 32'h0);
            chk("prio_p0_rsp_b", p0_rsp_valid_b, 1'b1);
            nxt();
        end
        idle(4);

        // B: RD_LAT=3, LBU 0x21; data must come from the last read cycle.
        p0_valid = 1'b1; p0_we = 1'b0; p0_func3 = F3_BU; p0_addr = 32'h21; mem_rdata = 32'h0;
        @(negedge clk);
        chk("lat3_ready", p0_ready_b, 1'b1);
        nxt(); p0_valid = 1'b0; mem_rdata = 32'h1111;
        @(negedge clk);
        chk("lat3_c1_rd", mem_rd_b, 1'b1);
        chk("lat3_c1_func3", mem_func3_b, 3'b100);
        chk("lat3_c1_addr", mem_addr_b, 32'h21);
        nxt(); mem_rdata = 32'h2222;
        @(negedge clk);
        chk("lat3_c2_rd", mem_rd_b, 1'b1);
        chk("lat3_c2_rsp", p0_rsp_valid_b, 1'b0);
        nxt(); mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("lat3_c3_rd", mem_rd_b, 1'b1);
        chk("lat3_c3_rsp", p0_rsp_valid_b, 1'b0);
        nxt(); mem_rdata = 32'h0;
        @(negedge clk);
        chk("lat3_c4_rsp", p0_rsp_valid_b, 1'b1);
        chk("lat3_c4_err", p0_rsp_err_b, 1'b0);
        chk("lat3_c4_rdata", rsp_rdata_b, 32'h12345678);
        chk("lat3_c4_rd", mem_rd_b, 1'b0);
        nxt(); @(negedge clk);
        chk("lat3_c5_rsp", p0_rsp_valid_b, 1'b0);
        idle(3);

        // Reset asserted mid-read on B.
        p0_valid = 1'b1; p0_we = 1'b0; p0_func3 = F3_W; p0_addr = 32'h40; mem_rdata = 32'h55;
        @(negedge clk);
        chk("mid_ready", p0_ready_b, 1'b1);
        nxt(); p0_valid = 1'b0;
        @(negedge clk);
        chk("mid_rd_before", mem_rd_b, 1'b1);
        nxt();
        rst = 1'b0;
        #1;
        chk("mid_rd_async", mem_rd_b, 1'b0);
        chk("mid_addr_async", mem_addr_b, 32'h0);
        chk("mid_func3_async", mem_func3_b, 3'b000);
        chk("mid_rdata_async", rsp_rdata_b, 32'h0);
        chk("mid_rsp_async", p0_rsp_valid_b, 1'b0);
        repeat (2) nxt();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_b", p0_rsp_valid_b, 1'b0);
            chk("post_rst_rsp_a", p0_rsp_valid_a, 1'b0);
        end

        // After reset: tie goes to p0 on A, p1 next; B grants p0 normally.
        nxt();
        p0_valid = 1'b1; p0_we = 1'b1; p0_func3 = F3_W; p0_addr = 32'h300; p0_wdata = 32'hC3;
        p1_valid = 1'b1; p1_we = 1'b1; p1_func3 = F3_W; p1_addr = 32'h400; p1_wdata = 32'hD4;
        @(negedge clk);
        chk("rel_p0_ready_a", p0_ready_a, 1'b1);
        chk("rel_p1_ready_a", p1_ready_a, 1'b0);
        chk("rel_p0_ready_b", p0_ready_b, 1'b1);
        nxt(); @(negedge clk);
        chk("rel_mem_wr_b", mem_wr_b, 1'b1);
        chk("rel_wdata_b", mem_wdata_b, 32'hC3);
        nxt(); @(negedge clk);
        chk("rel_rsp_b", p0_rsp_valid_b, 1'b1);
        nxt(); @(negedge clk);
        chk("rel_p1_ready_a", p1_ready_a, 1'b1);
        chk("rel_p0_ready_b2", p0_ready_b, 1'b1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
